bomb_pool: RTL

- Multi-slot bomb manager that replaces the single-bomb latch in the game datapath.
- Holds up to NUM_BOMBS bombs at once. Each bomb records its grid position and its owner colour.
- Each bomb's fuse counts down on game ticks, then the bomb goes through an explosion phase and its slot is freed.
- Sits between player input logic and the renderer and collision logic, which read the per-slot position and state vectors.

---
 rtl/bomb_pool.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bomb_pool.sv
// rtl/bomb_pool.sv - multi-slot bomb manager with per-slot fuse and blast countdowns
module bomb_pool #(
    parameter int COORD_W     = 6,
    parameter int NUM_BOMBS   = 4,
    parameter int FUSE_TICKS  = 8,
    parameter int BLAST_TICKS = 3,
    parameter int CNT_W       = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           tick,
    input  logic                           bombDropped,
    input  logic [COORD_W-1:0]             positionX,
    input  logic [COORD_W-1:0]             positionY,
    input  logic                           color,
    output logic                           dropAck,
    output logic                           dropReject,
    output logic [NUM_BOMBS*COORD_W-1:0]   bombX,
    output logic [NUM_BOMBS*COORD_W-1:0]   bombY,
    output logic [NUM_BOMBS-1:0]           bombColor,
    output logic [NUM_BOMBS-1:0]           bombEnable,
    output logic [NUM_BOMBS-1:0]           bombExploding,
    output logic [NUM_BOMBS-1:0]           explodePulse,
    output logic                           poolFull
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_BLAST = 2'd2
    } slot_state_e;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] FUSE_CNT  = CNT_W'(FUSE_TICKS);
    localparam logic [CNT_W-1:0] BLAST_CNT = CNT_W'(BLAST_TICKS);

    slot_state_e                  state_q [NUM_BOMBS];
    slot_state_e                  state_d [NUM_BOMBS];
    logic [CNT_W-1:0]             cnt_q   [NUM_BOMBS];
    logic [CNT_W-1:0]             cnt_d   [NUM_BOMBS];
    logic [NUM_BOMBS*COORD_W-1:0] bomb_x_q, bomb_x_d;
    logic [NUM_BOMBS*COORD_W-1:0] bomb_y_q, bomb_y_d;
    logic [NUM_BOMBS-1:0]         color_q, color_d;
    logic [NUM_BOMBS-1:0]         enable_q, enable_d;
    logic [NUM_BOMBS-1:0]         exploding_q, exploding_d;
    logic [NUM_BOMBS-1:0]         pulse_q, pulse_d;
    logic                         drop_ack_q, drop_ack_d;
    logic                         drop_reject_q, drop_reject_d;
    logic                         pool_full_q, pool_full_d;

    logic                         dup_hit;
    logic                         alloc_found;
    logic [NUM_BOMBS-1:0]         alloc_sel;

    // Both the duplicate check and free-slot search look only at start-of-cycle
    // state, so a slot retiring this cycle is neither free nor ignored.
    always_comb begin
        dup_hit     = 1'b0;
        alloc_found = 1'b0;
        alloc_sel   = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (state_q[i] != S_IDLE &&
                bomb_x_q[i*COORD_W +: COORD_W] == positionX &&
                bomb_y_q[i*COORD_W +: COORD_W] == positionY) begin
                dup_hit = 1'b1;
            end
            if (!alloc_found && state_q[i] == S_IDLE) begin
                alloc_sel[i] = 1'b1;
                alloc_found  = 1'b1;
            end
        end
        if (!bombDropped || dup_hit) begin
            alloc_sel = '0;
        end
        drop_ack_d    = bombDropped && !dup_hit && alloc_found;
        drop_reject_d = bombDropped && !drop_ack_d;
    end

    always_comb begin
        bomb_x_d = bomb_x_q;
        bomb_y_d = bomb_y_q;
        color_d  = color_q;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pulse_d[i] = 1'b0;
            if (alloc_sel[i]) begin
                state_d[i]                      = S_ARMED;
                cnt_d[i]                        = FUSE_CNT;
                bomb_x_d[i*COORD_W +: COORD_W]  = positionX;
                bomb_y_d[i*COORD_W +: COORD_W]  = positionY;
                color_d[i]                      = color;
            end else if (tick) begin
                case (state_q[i])
                    S_ARMED: begin
                        if (cnt_q[i] > CNT_ONE) begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end else begin
                            state_d[i] = S_BLAST;
                            cnt_d[i]   = BLAST_CNT;
                            pulse_d[i] = 1'b1;
                        end
                    end
                    S_BLAST: begin
                        if (cnt_q[i] > CNT_ONE) begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end else begin
                            state_d[i] = S_IDLE;
                            cnt_d[i]   = '0;
                        end
                    end
                    default: ;
                endcase
            end
            enable_d[i]    = (state_d[i] != S_IDLE);
            exploding_d[i] = (state_d[i] == S_BLAST);
        end
        pool_full_d = &enable_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
            end
            bomb_x_q      <= '0;
            bomb_y_q      <= '0;
            color_q       <= '0;
            enable_q      <= '0;
            exploding_q   <= '0;
            pulse_q       <= '0;
            drop_ack_q    <= 1'b0;
            drop_reject_q <= 1'b0;
            pool_full_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            bomb_x_q      <= bomb_x_d;
            bomb_y_q      <= bomb_y_d;
            color_q       <= color_d;
            enable_q      <= enable_d;
            exploding_q   <= exploding_d;
            pulse_q       <= pulse_d;
            drop_ack_q    <= drop_ack_d;
            drop_reject_q <= drop_reject_d;
            pool_full_q   <= pool_full_d;
        end
    end

    assign dropAck       = drop_ack_q;
    assign dropReject    = drop_reject_q;
    assign bombX         = bomb_x_q;
    assign bombY         = bomb_y_q;
    assign bombColor     = color_q;
    assign bombEnable    = enable_q;
    assign bombExploding = exploding_q;
    assign explodePulse  = pulse_q;
    assign poolFull      = pool_full_q;

endmodule
